mod_stream_reducer: RTL and testbench



---
 rtl/mod_stream_reducer.sv | 96 +++++++++
 tb/tb_mod_stream_reducer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_stream_reducer.sv
// mod_stream_reducer: reduces a wide unsigned operand, streamed in
// CHUNK_W-bit chunks most-significant first, to (operand mod MOD).
// Horner accumulation: acc <- (acc * 2^CHUNK_W + chunk) mod MOD, with the
// modulo done by CHUNK_W conditional-subtract stages of MOD<<k.
// Operands longer than N_CHUNKS are cut at N_CHUNKS and flagged with out_err.
module mod_stream_reducer #(
  parameter int unsigned MOD      = 107,
  parameter int unsigned CHUNK_W  = 6,
  parameter int unsigned N_CHUNKS = 50,
  parameter int unsigned RES_W    = $clog2(MOD),
  parameter int unsigned CNT_W    = $clog2(N_CHUNKS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_res,
  output logic [CNT_W-1:0]   out_cnt,
  output logic               out_err
);

  localparam int unsigned TW = RES_W + CHUNK_W;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0]       state;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [TW-1:0]    t_red;
  logic [RES_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             finish;

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign finish    = in_last | (cnt_inc == CNT_W'(N_CHUNKS));

  // Shift the chunk into the running residue and fold it back below MOD.
  // t = acc*2^CHUNK_W + in_data never exceeds MOD*2^CHUNK_W - 1, so one
  // conditional subtract of MOD<<k per k (largest first) is sufficient.
  always_comb begin
    t_red = {acc, in_data};
    for (int unsigned i = 0; i < CHUNK_W; i++) begin
      if (t_red >= (TW'(MOD) << (CHUNK_W - 1 - i))) begin
        t_red = t_red - (TW'(MOD) << (CHUNK_W - 1 - i));
      end
    end
    acc_next = RES_W'(t_red);
  end

  // Control FSM plus accumulator, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACC;
      acc     <= '0;
      cnt     <= '0;
      out_res <= '0;
      out_cnt <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (finish) begin
              out_res <= acc_next;
              out_cnt <= cnt_inc;
              out_err <= ~in_last;
              acc     <= '0;
              cnt     <= '0;
              state   <= ST_DONE;
            end else begin
              acc <= acc_next;
              cnt <= cnt_inc;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_stream_reducer.sv
// Bench for mod_stream_reducer: fixed vectors, hand-written corner sequences,
// and random streams checked against a chunk-queue reference model.
module tb_mod_stream_reducer;

  localparam int MODV = 107;
  localparam int CW   = 6;
  localparam int NC   = 50;
  localparam int RW   = $clog2(MODV);
  localparam int KW   = $clog2(NC + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_res;
  logic [KW-1:0] out_cnt;
  logic          out_err;

  mod_stream_reducer #(
    .MOD(MODV),
    .CHUNK_W(CW),
    .N_CHUNKS(NC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res(out_res),
    .out_cnt(out_cnt),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: chunks of the current operand are kept in a queue and
  // the operand value is reduced with plain % once it terminates.
  typedef struct { int res; int cnt; int err; } res_t;
  res_t exp_q[$];
  int   cur_q[$];
  bit   mon_en = 0;
  bit   gap_en = 0;
  bit   rand_ready = 0;

  function automatic void model_accept(input int d, input bit last);
    int r;
    res_t e;
    cur_q.push_back(d);
    if (last || cur_q.size() == NC) begin
      r = 0;
      foreach (cur_q[i]) r = (r * (1 << CW) + cur_q[i]) % MODV;
      e.res = r;
      e.cnt = cur_q.size();
      e.err = last ? 0 : 1;
      exp_q.push_back(e);
      cur_q.delete();
    end
  endfunction

  // Drives one chunk; called between a falling edge and the next rising edge,
  // returns on the falling edge after the chunk was accepted.
  task automatic send(input int d, input bit last);
    int w;
    logic [31:0] dv;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        dv = $urandom;
        in_data = dv[CW-1:0];
        in_last = dv[8];
        @(negedge clk);
      end
    end
    dv = d;
    in_valid = 1'b1;
    in_data  = dv[CW-1:0];
    in_last  = last;
    w = 0;
    while (!in_ready) begin
      @(negedge clk);
      w++;
      if (w > 1000) begin
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    if (mon_en) model_accept(d, last);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Random consumer backpressure.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Result monitor: every cycle a result is presented it must equal the head
  // of the expected queue (this also covers stability under backpressure).
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !rst) begin
        chk("mon_in_ready", in_ready, !out_valid);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("mon_spurious_result", 1, 0);
          end else begin
            e = exp_q[0];
            chk("mon_res", out_res, e.res);
            chk("mon_cnt", out_cnt, e.cnt);
            chk("mon_err", out_err, e.err);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { int n; int d[4]; int res; int cnt; } vec_t;
  vec_t tbl[7];

  initial begin
    int w;
    int n;
    logic [31:0] rv;

    tbl[0] = '{1, '{45, 0, 0, 0}, 45, 1};
    tbl[1] = '{2, '{2, 0, 0, 0}, 21, 2};      // 128 mod 107
    tbl[2] = '{2, '{63, 63, 0, 0}, 29, 2};    // 4095 mod 107
    tbl[3] = '{4, '{1, 0, 0, 0}, 101, 4};     // 2^18 mod 107
    tbl[4] = '{1, '{0, 0, 0, 0}, 0, 1};
    tbl[5] = '{3, '{1, 2, 3, 0}, 54, 3};      // 4227 mod 107
    tbl[6] = '{3, '{63, 63, 63, 0}, 100, 3};  // (2^18 - 1) mod 107

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_err", out_err, 0);

    // Fixed vectors, gap-free, consumer always ready
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < tbl[v].n; i++) send(tbl[v].d[i], i == tbl[v].n - 1);
      #2;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_in_ready_busy", in_ready, 0);
      chk("vec_out_res", out_res, tbl[v].res);
      chk("vec_out_cnt", out_cnt, tbl[v].cnt);
      chk("vec_out_err", out_err, 0);
      @(negedge clk);
      #2;
      chk("vec_out_valid_drop", out_valid, 0);
      chk("vec_in_ready_back", in_ready, 1);
    end

    // Backpressure: result held for 5 cycles, chunks offered meanwhile ignored
    out_ready = 1'b0;
    send(63, 1'b1);
    in_valid = 1'b1;
    in_data  = 6'd5;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_res", out_res, 63);
      chk("bp_out_cnt", out_cnt, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    #2;
    chk("bp_still_valid", out_valid, 1);
    chk("bp_res_at_take", out_res, 63);
    @(negedge clk);
    #2;
    chk("bp_consumed", out_valid, 0);
    chk("bp_in_ready", in_ready, 1);
    @(negedge clk);
    #2;
    chk("bp_no_ghost", out_valid, 0);

    // Reset mid-operand discards the partial accumulation
    send(7, 1'b0);
    send(9, 1'b0);
    send(11, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_res", out_res, 0);
    chk("mrst_out_cnt", out_cnt, 0);
    chk("mrst_in_ready", in_ready, 1);
    send(10, 1'b1);
    #2;
    chk("mrst_new_valid", out_valid, 1);
    chk("mrst_new_res", out_res, 10);
    chk("mrst_new_cnt", out_cnt, 1);
    chk("mrst_new_err", out_err, 0);
    @(negedge clk);

    // Random streams against the reference model
    mon_en = 1;
    rand_ready = 1;
    for (int i = 0; i < 50; i++) begin
      rv = $urandom;
      send(int'(rv[CW-1:0]), i == 49);
    end
    for (int i = 0; i < 60; i++) begin
      rv = $urandom;
      send(int'(rv[CW-1:0]), i == 59);
    end
    gap_en = 1;
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        rv = $urandom;
        send(int'(rv[CW-1:0]), i == n - 1);
      end
    end
    send(1, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    send(0, 1'b1);
    gap_en = 0;

    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending_results", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    mon_en = 0;
    rand_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
